// File: rtl/seq_scan_pkg.sv
// Shared types and default constants for the serial sequence scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned PAT_W_DEF  = 7;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 7'b1011010;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping serial pattern matcher: bit history, bits-seen counter and registered match pulse.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int unsigned          PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0]     PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bit_valid,
  input  logic i_bit_in,
  input  logic i_flush,
  output logic o_hit,
  output logic o_match_pulse
);

  localparam int unsigned SEEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_hist;
  logic [SEEN_W-1:0] r_seen;
  logic              r_match_pulse;
  logic [PAT_W-1:0]  w_hist_n;
  logic              w_hit;

  always_comb begin
    w_hist_n = {r_hist[PAT_W-2:0], i_bit_in};
    // The history is never cleared on a match, so overlapping patterns are found.
    w_hit    = i_bit_valid && (w_hist_n == PATTERN) && (r_seen >= SEEN_W'(PAT_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist        <= '0;
      r_seen        <= '0;
      r_match_pulse <= 1'b0;
    end else begin
      r_match_pulse <= w_hit;
      if (i_flush) begin
        r_hist <= '0;
        r_seen <= '0;
      end else if (i_bit_valid) begin
        r_hist <= w_hist_n;
        if (r_seen != SEEN_W'(PAT_W)) begin
          r_seen <= r_seen + SEEN_W'(1);
        end
      end
    end
  end

  assign o_hit         = w_hit;
  assign o_match_pulse = r_match_pulse;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame-based scan controller: accepts words over valid/ready, shifts them MSB-first into the
// matcher, counts matches with saturation and raises a sticky threshold interrupt.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned      WORD_W  = WORD_W_DEF,
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int unsigned      CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WORD_W-1:0] i_in_data,
  input  logic              i_in_last,
  input  logic [CNT_W-1:0]  i_thresh,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_match_pulse,
  output logic [CNT_W-1:0]  o_match_count,
  output logic              o_frame_done,
  output logic              o_irq
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e            r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_last;
  logic              r_frame_done;
  logic [CNT_W-1:0]  r_count;
  logic              r_irq;

  logic              w_bit_valid;
  logic              w_flush;
  logic              w_idx_zero;
  logic              w_hit;
  logic [CNT_W-1:0]  w_count_next;

  always_comb begin
    w_bit_valid = (r_state == S_SHIFT);
    w_flush     = (r_state == S_DONE);
    w_idx_zero  = (r_bit_idx == '0);
    // Ready mid-SHIFT only on the final bit of a non-last word, giving gapless back-to-back words.
    o_in_ready  = (r_state == S_IDLE) || ((r_state == S_SHIFT) && w_idx_zero && !r_last);
    o_busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_bit_idx    <= '0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_shreg   <= i_in_data;
            r_last    <= i_in_last;
            r_bit_idx <= IDX_W'(WORD_W - 1);
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
          r_bit_idx <= r_bit_idx - IDX_W'(1);
          if (w_idx_zero) begin
            if (r_last) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else if (i_in_valid) begin
              r_shreg   <= i_in_data;
              r_last    <= i_in_last;
              r_bit_idx <= IDX_W'(WORD_W - 1);
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  seq_match_core #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_match (
    .clk          (clk),
    .rst          (rst),
    .i_bit_valid  (w_bit_valid),
    .i_bit_in     (r_shreg[WORD_W-1]),
    .i_flush      (w_flush),
    .o_hit        (w_hit),
    .o_match_pulse(o_match_pulse)
  );

  always_comb begin
    w_count_next = r_count;
    if (w_hit && (r_count != {CNT_W{1'b1}})) begin
      w_count_next = r_count + CNT_W'(1);
    end
  end

  // irq is compared only on a match, so lowering the threshold below the count never sets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_irq   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_hit && (i_thresh != '0) && (w_count_next == i_thresh)) begin
        r_irq <= 1'b1;
      end
    end
  end

  assign o_match_count = r_count;
  assign o_frame_done  = r_frame_done;
  assign o_irq         = r_irq;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: directed frames push expected events, a negedge monitor checks them.
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [7:0]  i_in_data;
  logic        i_in_last;
  logic [15:0] i_thresh;
  logic        i_clear;
  logic        o_busy;
  logic        o_match_pulse;
  logic [15:0] o_match_count;
  logic        o_frame_done;
  logic        o_irq;

  typedef struct {
    string tag;
    int    kind;  // 0 = match pulse, 1 = frame done
    int    dly;   // cycles after the frame's first handshake edge
    int    cnt;
    int    irq;
  } evt_t;

  evt_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   base = 0;
  int   busy_gaps = 0;
  logic watch_busy = 1'b0;

  seq_scan_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .i_in_last    (i_in_last),
    .i_thresh     (i_thresh),
    .i_clear      (i_clear),
    .o_busy       (o_busy),
    .o_match_pulse(o_match_pulse),
    .o_match_count(o_match_count),
    .o_frame_done (o_frame_done),
    .o_irq        (o_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input string tag, input int kind, input int dly, input int cnt,
                            input int irq);
    evt_t e;
    e.tag = tag; e.kind = kind; e.dly = dly; e.cnt = cnt; e.irq = irq;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int kind);
    evt_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d want none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_kind"}, kind, e.kind);
      chk({e.tag, "_delay"}, cyc - base, e.dly);
      chk({e.tag, "_count"}, int'(o_match_count), e.cnt);
      chk({e.tag, "_irq"}, int'(o_irq), e.irq);
    end
  endtask

  // Monitor: events first, then note a frame-start handshake about to happen on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_match_pulse) pop_chk(0);
      if (o_frame_done) pop_chk(1);
      if (i_in_valid && o_in_ready && !o_busy) base = cyc + 1;
      if (watch_busy && !o_busy) busy_gaps++;
    end
  end

  task automatic send(input logic [7:0] d, input logic l, output int t);
    int n;
    n = 0;
    i_in_valid = 1'b1;
    i_in_data  = d;
    i_in_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!o_in_ready && n < 100);
    if (!o_in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    t = cyc;
    i_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, int'(o_in_ready), 1);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_count"}, int'(o_match_count), 0);
    chk({tag, "_irq"}, int'(o_irq), 0);
    chk({tag, "_pulse"}, int'(o_match_pulse), 0);
    chk({tag, "_frame_done"}, int'(o_frame_done), 0);
  endtask

  initial begin
    int t, tprev;
    rst = 1'b1;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_in_last = 1'b0;
    i_thresh = '0;
    i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outs("post_reset");

    // Single word: match on bit 7, frame done after bit 8.
    expect_evt("single_m", 0, 7, 1, 0);
    expect_evt("single_f", 1, 8, 1, 0);
    send(8'b10110100, 1'b1, t);
    wait_drain("single");

    // Overlapping matches spanning two words of one frame.
    expect_evt("ovl_m1", 0, 7, 2, 0);
    expect_evt("ovl_m2", 0, 12, 3, 0);
    expect_evt("ovl_f", 1, 16, 3, 0);
    send(8'b10110101, 1'b0, t);
    send(8'b10100000, 1'b1, t);
    wait_drain("overlap");

    // The pattern straddles a frame boundary and must not match.
    expect_evt("iso_f1", 1, 8, 3, 0);
    expect_evt("iso_f2", 1, 8, 3, 0);
    send(8'b00000101, 1'b1, t);
    send(8'b10100000, 1'b1, t);
    wait_drain("isolation");

    // Back-to-back words with valid held: one accept per 8 cycles, busy never drops.
    expect_evt("b2b_f", 1, 40, 3, 0);
    busy_gaps = 0;
    send(8'h00, 1'b0, tprev);
    watch_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'h00, (i == 3), t);
      chk("b2b_accept_spacing", t - tprev, 8);
      tprev = t;
    end
    watch_busy = 1'b0;
    chk("b2b_busy_gaps", busy_gaps, 0);
    wait_drain("b2b");

    // Threshold IRQ, then clear landing on a match cycle.
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    chk("clear_count", int'(o_match_count), 0);
    chk("clear_irq", int'(o_irq), 0);
    i_thresh = 16'd2;
    expect_evt("thr_m1", 0, 7, 1, 0);
    expect_evt("thr_m2", 0, 12, 2, 1);
    expect_evt("thr_f", 1, 16, 2, 1);
    send(8'b10110101, 1'b0, t);
    send(8'b10100000, 1'b1, t);
    wait_drain("thresh");
    chk("irq_sticky", int'(o_irq), 1);

    expect_evt("clr_m1", 0, 7, 3, 1);
    expect_evt("clr_m2", 0, 12, 0, 0);
    expect_evt("clr_f", 1, 16, 0, 0);
    fork
      begin
        int ts;
        send(8'b10110101, 1'b0, ts);
        send(8'b10100000, 1'b1, ts);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!o_match_pulse && n < 100);
        repeat (4) @(posedge clk);
        #1;
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
      end
    join
    wait_drain("clear_on_match");
    i_thresh = '0;

    // Asynchronous reset mid-SHIFT discards the partial pattern.
    expect_evt("pre_rst_m", 0, 7, 1, 0);
    expect_evt("pre_rst_f", 1, 8, 1, 0);
    send(8'b10110100, 1'b1, t);
    wait_drain("pre_rst");
    send(8'b10110100, 1'b0, t);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_rst_in_ready", int'(o_in_ready), 1);
    expect_evt("post_rst_f", 1, 8, 0, 0);
    send(8'b01000000, 1'b1, t);
    wait_drain("post_rst");

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
